// File: rtl/mult_div_unit_if.sv
// Bus between the EX stage and the multiply/divide unit.
//   master: EX side, drives launch/MTHI/MTLO requests and operands, reads HI/LO/status.
//   slave : mult_div_unit, consumes requests and drives HI/LO, Busy, Div_By_Zero.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start_E;
  logic [1:0]       Md_Op_E;
  logic [WIDTH-1:0] Src_A_E;
  logic [WIDTH-1:0] Src_B_E;
  logic             Mthi_E;
  logic             Mtlo_E;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Div_By_Zero;

  modport master (
    output Start_E, Md_Op_E, Src_A_E, Src_B_E, Mthi_E, Mtlo_E,
    input  Hi, Lo, Busy, Div_By_Zero
  );

  modport slave (
    input  Start_E, Md_Op_E, Src_A_E, Src_B_E, Mthi_E, Mtlo_E,
    output Hi, Lo, Busy, Div_By_Zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One multiplier/quotient bit per cycle over CYCLES cycles; signed ops run on
// magnitudes with sign fixup at write-back. Also performs MTHI/MTLO.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   md  - slave side of mult_div_unit_if (requests, operands, HI/LO, Busy, Div_By_Zero)
module mult_div_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CYCLES = WIDTH
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave md
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0] acc;       // MUL: {partial, multiplier}; DIV: {remainder, dividend}
  logic [WIDTH-1:0]   src_a;     // raw Src_A for divide-by-zero write-back
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder
  logic               div_zero;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Operand magnitudes at launch and one iteration step of each algorithm.
  always_comb begin
    is_signed = ~md.Md_Op_E[0];
    a_neg     = is_signed & md.Src_A_E[WIDTH-1];
    b_neg     = is_signed & md.Src_B_E[WIDTH-1];
    a_mag     = a_neg ? -md.Src_A_E : md.Src_A_E;
    b_mag     = b_neg ? -md.Src_B_E : md.Src_B_E;

    // Shift-add: add multiplicand on LSB of multiplier, shift whole accumulator right.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into remainder, subtract if it fits.
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, opnd};
    div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opnd}) : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

    step_next = (state == DIV) ? div_next : mul_next;

    prod_fix  = neg_q ? -mul_next : mul_next;
    q_fix     = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    r_fix     = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  // Control FSM, datapath registers and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      opnd           <= '0;
      acc            <= '0;
      src_a          <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      div_zero       <= 1'b0;
      md.Hi          <= '0;
      md.Lo          <= '0;
      md.Busy        <= 1'b0;
      md.Div_By_Zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.Start_E) begin
            state          <= md.Md_Op_E[1] ? DIV : MUL;
            count          <= CNT_W'(CYCLES);
            md.Busy        <= 1'b1;
            md.Div_By_Zero <= 1'b0;
            src_a          <= md.Src_A_E;
            neg_q          <= a_neg ^ b_neg;
            neg_r          <= a_neg;
            div_zero       <= (md.Src_B_E == '0);
            if (md.Md_Op_E[1]) begin
              opnd <= b_mag;
              acc  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd <= a_mag;
              acc  <= {{WIDTH{1'b0}}, b_mag};
            end
          end else begin
            if (md.Mthi_E) md.Hi <= md.Src_A_E;
            if (md.Mtlo_E) md.Lo <= md.Src_A_E;
          end
        end

        MUL, DIV: begin
          acc   <= step_next;
          count <= count - CNT_W'(1);
          // Last iteration: write back with sign fixup and release Busy.
          if (count == CNT_W'(1)) begin
            state   <= IDLE;
            md.Busy <= 1'b0;
            if (state == DIV) begin
              if (div_zero) begin
                md.Hi          <= src_a;
                md.Lo          <= '1;
                md.Div_By_Zero <= 1'b1;
              end else begin
                md.Hi <= r_fix;
                md.Lo <= q_fix;
              end
            end else begin
              {md.Hi, md.Lo} <= prod_fix;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences (ignored requests, MTHI/MTLO, reset abort) and random
// ops checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  // Reference: plain 64-bit arithmetic (C-style truncating division).
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          hi = sr[31:0]; lo = sq[31:0];
        end else begin
          up = ua / ub; hi = 32'(ua % ub); lo = up[31:0];
        end
      end
    endcase
  endfunction

  // Launch an op at the next rising edge and wait for Busy to drop.
  // cyc counts sampled cycles with Busy high; dz0 is Div_By_Zero just after launch.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic dz0);
    @(negedge clk);
    bus.Start_E = 1'b1; bus.Md_Op_E = op; bus.Src_A_E = a; bus.Src_B_E = b;
    @(negedge clk);
    bus.Start_E = 1'b0;
    dz0 = bus.Div_By_Zero;
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          cyc;
    logic        dz0;
    logic [31:0] ehi, elo;
    logic        edz;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = mk(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    vecs[1]  = mk(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    vecs[2]  = mk(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    vecs[3]  = mk(2'b11, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    vecs[4]  = mk(2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0);
    vecs[5]  = mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    vecs[6]  = mk(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    vecs[7]  = mk(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    vecs[8]  = mk(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    vecs[9]  = mk(2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    vecs[10] = mk(2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    vecs[11] = mk(2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0);

    rst = 1'b1;
    bus.Start_E = 1'b0; bus.Md_Op_E = 2'b00; bus.Src_A_E = '0; bus.Src_B_E = '0;
    bus.Mthi_E = 1'b0; bus.Mtlo_E = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi",   64'(bus.Hi), 64'h0);
    chk("reset_lo",   64'(bus.Lo), 64'h0);
    chk("reset_busy", 64'(bus.Busy), 64'h0);
    chk("reset_dz",   64'(bus.Div_By_Zero), 64'h0);
    rst = 1'b0;

    // Directed vectors; each launch must clear Div_By_Zero at acceptance.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dz0);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'd32);
      chk($sformatf("vec%0d_dz_at_start", i), 64'(dz0), 64'h0);
      chk($sformatf("vec%0d_hi", i), 64'(bus.Hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(bus.Lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dz", i), 64'(bus.Div_By_Zero), 64'(vecs[i].dz));
    end

    // MULTU 5x6 with a stray start at cycle 10 and MTHI at cycle 11 (both ignored).
    @(negedge clk);
    bus.Start_E = 1'b1; bus.Md_Op_E = 2'b01; bus.Src_A_E = 32'd5; bus.Src_B_E = 32'd6;
    bus.Mthi_E = 1'b1;  // Start has priority over MTHI in the same cycle
    @(negedge clk);
    bus.Start_E = 1'b0; bus.Mthi_E = 1'b0;
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 10) begin
        bus.Start_E = 1'b1; bus.Md_Op_E = 2'b11; bus.Src_A_E = 32'd100; bus.Src_B_E = 32'd7;
      end else if (cyc == 11) begin
        bus.Start_E = 1'b0; bus.Mthi_E = 1'b1; bus.Src_A_E = 32'h1234;
      end else begin
        bus.Start_E = 1'b0; bus.Mthi_E = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start_E = 1'b0; bus.Mthi_E = 1'b0;
    chk("ignore_busy_cycles", 64'(cyc), 64'd32);
    chk("ignore_hi", 64'(bus.Hi), 64'h0);
    chk("ignore_lo", 64'(bus.Lo), 64'd30);

    // MTHI / MTLO / both in IDLE.
    bus.Mthi_E = 1'b1; bus.Src_A_E = 32'h1234;
    @(negedge clk);
    bus.Mthi_E = 1'b0;
    chk("mthi_hi", 64'(bus.Hi), 64'h1234);
    chk("mthi_lo_kept", 64'(bus.Lo), 64'd30);
    bus.Mtlo_E = 1'b1; bus.Src_A_E = 32'hABCD;
    @(negedge clk);
    bus.Mtlo_E = 1'b0;
    chk("mtlo_lo", 64'(bus.Lo), 64'hABCD);
    chk("mtlo_hi_kept", 64'(bus.Hi), 64'h1234);
    bus.Mthi_E = 1'b1; bus.Mtlo_E = 1'b1; bus.Src_A_E = 32'h55;
    @(negedge clk);
    bus.Mthi_E = 1'b0; bus.Mtlo_E = 1'b0;
    chk("mtboth_hi", 64'(bus.Hi), 64'h55);
    chk("mtboth_lo", 64'(bus.Lo), 64'h55);

    // Reset mid-DIV after a divide-by-zero left the flag set.
    run_op(2'b11, 32'd9, 32'd0, cyc, dz0);
    chk("pre_reset_dz", 64'(bus.Div_By_Zero), 64'h1);
    @(negedge clk);
    bus.Start_E = 1'b1; bus.Md_Op_E = 2'b10; bus.Src_A_E = 32'd100; bus.Src_B_E = 32'd7;
    @(negedge clk);
    bus.Start_E = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.Busy), 64'h0);
    chk("abort_hi",   64'(bus.Hi), 64'h0);
    chk("abort_lo",   64'(bus.Lo), 64'h0);
    chk("abort_dz",   64'(bus.Div_By_Zero), 64'h0);
    run_op(2'b10, 32'd100, 32'd7, cyc, dz0);
    chk("post_reset_busy_cycles", 64'(cyc), 64'd32);
    chk("post_reset_lo", 64'(bus.Lo), 64'd14);
    chk("post_reset_hi", 64'(bus.Hi), 64'd2);

    // Random ops against the reference model, biased toward corner operands.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: rb = 32'h0;
        3: rb = 32'hFFFF_FFFF;
        4: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      ref_model(rop, ra, rb, ehi, elo, edz);
      run_op(rop, ra, rb, cyc, dz0);
      chk($sformatf("rnd%0d_busy_cycles", n), 64'(cyc), 64'd32);
      chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, rop, ra, rb), 64'(bus.Hi), 64'(ehi));
      chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, rop, ra, rb), 64'(bus.Lo), 64'(elo));
      chk($sformatf("rnd%0d_dz", n), 64'(bus.Div_By_Zero), 64'(edz));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
